rv_tdpram: RTL and testbench
============================

Name: rv_tdpram

Overview:
- Parametrised true dual-port RAM, single clock; successor to the basic dual-port RAM used for the core's instruction and data stores.
- Adds per-byte write enables and a selectable read latency of 1 or 2 cycles.
- Adds a defined same-port read-during-write mode and deterministic cross-port collision rules.
- Adds an optional post-reset zero-fill sequencer with an init_done flag.
- Sits between the pipeline LSU/IFU and the bus bridge, or serves as a shared scratch memory.

Parameters:
- WIDTH, 32: data width in bits; must be a multiple of 8.
- DEPTH, 1024: number of words; need not be a power of 2.
- RD_LAT, 1: read latency in cycles; legal values 1 or 2.
- RDW_MODE, 0: same-port read-during-write; 0 = read-first (old data), 1 = write-first (new data).
- CLR_ON_RST, 1: 1 = zero-fill every word after reset release; 0 = no fill.
- Derived: AW = clog2(DEPTH), minimum 1; BW = WIDTH/8.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- init_done  out  1  high once the memory accepts accesses.
- a_en  in  1  port A access request.
- a_we  in  BW  port A byte write enables; all zero = read.
- a_addr  in  AW  port A word address.
- a_wdata  in  WIDTH  port A write data.
- a_rdata  out  WIDTH  port A read data.
- a_rvalid  out  1  port A read data valid, one-cycle pulse.
- b_en, b_we, b_addr, b_wdata, b_rdata, b_rvalid: identical to port A, for port B.

Behaviour:
Reset values:
- While rst_n=0: init_done=0, a_rdata=b_rdata=0, a_rvalid=b_rvalid=0, FSM in CLEAR.
- Reset does not alter array contents directly.

Init FSM, states CLEAR and READY:
- CLR_ON_RST=1: in CLEAR, the fill counter writes 0 to addresses 0..DEPTH-1, one word per cycle, starting the first clk after rst_n rises.
- CLR_ON_RST=1: the transition to READY happens on the edge that writes address DEPTH-1; init_done=1 from the following cycle; total DEPTH cycles.
- CLR_ON_RST=0: transition to READY on the first clk after reset release.
- In CLEAR, en/we are ignored: no writes, rvalid stays 0, rdata holds 0.
- rst_n asserted mid-fill aborts the fill; the fill restarts from address 0 after release.
- READY is terminal until the next reset.

Access rules, in READY, per port:
- Accepted access: en=1 with addr<DEPTH.
- Write: bytes i with we[i]=1 take wdata[8i+7:8i]; other bytes are unchanged.
- Read: en=1, we=0.
  - RD_LAT=1: rdata is valid and rvalid=1 on the cycle after the request.
  - RD_LAT=2: an extra output register stage; valid two cycles after the request.
- Back-to-back reads issue every cycle; full throughput, no stalls, no backpressure.
- Partial write (we≠0): rdata also updates with the RDW_MODE value at the same latency, but rvalid stays 0.
  - RDW_MODE=0: the pre-write word.
  - RDW_MODE=1: the merged post-write word.
- rdata holds its last value when no access is in flight.
- en=0: no array effect.
- addr≥DEPTH: write dropped; a read returns 0 with rvalid=1 at normal latency.

Cross-port collisions, same address, same cycle:
- Both write: per byte, port A wins where both enable the byte; bytes enabled by only one port take that port's data.
- One reads, the other writes: the reader returns the old (pre-write) word regardless of RDW_MODE.
- Both read: both get identical data.

Width and arithmetic:
- Fill counter is AW+1 bits to detect terminal count for non-power-of-2 DEPTH.
- Address compare is unsigned.

Test Plan:
1. Init fill: WIDTH=32, DEPTH=1000, CLR_ON_RST=1; release rst_n, drive a_en=1 during fill -> init_done rises exactly 1000 cycles after release; a_rvalid stays 0; read of address 999 returns 0x00000000.
2. Byte enables and latency: RD_LAT=1; write A addr 5 = 0xAABBCCDD with we=1111, then we=0101 with 0x11223344, then read -> a_rdata=0xAA22CC44, a_rvalid one cycle after the read; with RD_LAT=2 the same result arrives two cycles after.
3. Same-port RDW: addr 7 holds 0x0; write 0xFFFFFFFF with we=1111 -> RDW_MODE=0 gives rdata 0x00000000, RDW_MODE=1 gives 0xFFFFFFFF; rvalid stays 0 in both.
4. Cross-port collision: A writes 0x11111111 we=0011 and B writes 0x22222222 we=0110, both to addr 3 (previously 0) -> addr 3 reads 0x00221111; B reading addr 3 while A writes it returns the old value.
5. Reset mid-fill: assert rst_n after 300 fill cycles, release -> outputs are 0 during reset; init_done rises DEPTH cycles after the second release; the full array reads 0.
6. Out of range: DEPTH=1000; read addr 1010 -> rdata=0 with rvalid=1; write addr 1010 -> no word in 0..999 changes.

Source files
------------

// File: rtl/rv_tdpram.sv
// rv_tdpram: single-clock true dual-port RAM with byte write enables,
// 1- or 2-cycle read latency, selectable same-port read-during-write,
// fixed cross-port collision rules and an optional post-reset zero fill.
//
// Init FSM
//   state | meaning
//   CLEAR | zero-fill in progress (or one idle cycle when no fill); accesses ignored
//   READY | memory accepts accesses; terminal until the next reset
module rv_tdpram #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 1024,
  parameter int RD_LAT     = 1,
  parameter int RDW_MODE   = 0,
  parameter int CLR_ON_RST = 1,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int BW        = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             init_done,
  input  logic             a_en,
  input  logic [BW-1:0]    a_we,
  input  logic [AW-1:0]    a_addr,
  input  logic [WIDTH-1:0] a_wdata,
  output logic [WIDTH-1:0] a_rdata,
  output logic             a_rvalid,
  input  logic             b_en,
  input  logic [BW-1:0]    b_we,
  input  logic [AW-1:0]    b_addr,
  input  logic [WIDTH-1:0] b_wdata,
  output logic [WIDTH-1:0] b_rdata,
  output logic             b_rvalid
);

  // The fill counter carries one extra bit so DEPTH itself is representable.
  localparam logic [AW:0] DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [AW:0] FILL_LAST = (AW+1)'(DEPTH - 1);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [AW:0] fill_cnt;
  logic        fill_we;
  logic        ready;

  logic [WIDTH-1:0] mem [DEPTH];

  // Index 0 is port A, index 1 is port B.
  logic [1:0]            en_v;
  logic [1:0][BW-1:0]    we_v;
  logic [1:0][AW-1:0]    addr_v;
  logic [1:0][WIDTH-1:0] wdata_v;
  logic [1:0]            in_rng, wr, rd, upd;
  logic                  same_addr;
  logic [1:0][WIDTH-1:0] old_w, new_w, rd_val;
  logic [1:0][WIDTH-1:0] s1_data;
  logic [1:0]            s1_vld;
  logic [1:0][WIDTH-1:0] out_data;
  logic [1:0]            out_vld;

  assign en_v    = {b_en, a_en};
  assign we_v    = {b_we, a_we};
  assign addr_v  = {b_addr, a_addr};
  assign wdata_v = {b_wdata, a_wdata};

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= CLEAR;
    else        state_q <= state_d;
  end

  // FSM next state: leave CLEAR on the edge that writes the last word
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (CLR_ON_RST == 0 || fill_cnt == FILL_LAST) state_d = READY;
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  // FSM outputs
  always_comb begin
    ready   = (state_q == READY);
    fill_we = (state_q == CLEAR) && (CLR_ON_RST != 0);
  end

  assign init_done = ready;

  // Fill address counter; restarts from zero on every reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       fill_cnt <= '0;
    else if (fill_we) fill_cnt <= fill_cnt + (AW+1)'(1);
  end

  // Per-port request decode; out-of-range addresses still complete as reads
  always_comb begin
    same_addr = (addr_v[0] == addr_v[1]);
    for (int p = 0; p < 2; p++) begin
      in_rng[p] = ({1'b0, addr_v[p]} < DEPTH_W);
      upd[p]    = ready && en_v[p];
      wr[p]     = upd[p] && in_rng[p] && (|we_v[p]);
      rd[p]     = upd[p] && !(|we_v[p]);
    end
  end

  // Old word and post-write word per port; port A bytes applied last so A wins
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      old_w[p] = in_rng[p] ? mem[addr_v[p]] : '0;
      new_w[p] = old_w[p];
      if (wr[1] && (p == 1 || same_addr)) begin
        for (int i = 0; i < BW; i++)
          if (we_v[1][i]) new_w[p][8*i +: 8] = wdata_v[1][8*i +: 8];
      end
      if (wr[0] && (p == 0 || same_addr)) begin
        for (int i = 0; i < BW; i++)
          if (we_v[0][i]) new_w[p][8*i +: 8] = wdata_v[0][8*i +: 8];
      end
      // A port reading the other port's write target always sees old_w.
      rd_val[p] = (wr[p] && RDW_MODE == 1) ? new_w[p] : old_w[p];
    end
  end

  // Array writes: zero fill during CLEAR, otherwise both ports
  always_ff @(posedge clk) begin
    if (fill_we) begin
      mem[fill_cnt[AW-1:0]] <= '0;
    end else begin
      if (wr[0]) mem[addr_v[0]] <= new_w[0];
      if (wr[1]) mem[addr_v[1]] <= new_w[1];
    end
  end

  // First read stage; data holds when no access is issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data <= '0;
      s1_vld  <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (upd[p]) s1_data[p] <= rd_val[p];
        s1_vld[p] <= rd[p];
      end
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [1:0]            s1_upd;
      logic [1:0][WIDTH-1:0] s2_data;
      logic [1:0]            s2_vld;

      // Extra output register stage
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_upd  <= '0;
          s2_data <= '0;
          s2_vld  <= '0;
        end else begin
          s1_upd <= upd;
          for (int p = 0; p < 2; p++) begin
            if (s1_upd[p]) s2_data[p] <= s1_data[p];
            s2_vld[p] <= s1_vld[p];
          end
        end
      end

      assign out_data = s2_data;
      assign out_vld  = s2_vld;
    end else begin : g_lat1
      assign out_data = s1_data;
      assign out_vld  = s1_vld;
    end
  endgenerate

  assign a_rdata  = out_data[0];
  assign b_rdata  = out_data[1];
  assign a_rvalid = out_vld[0];
  assign b_rvalid = out_vld[1];

endmodule

// File: tb/tb_rv_tdpram.sv
// Directed bench for rv_tdpram: three instances sharing one stimulus.
//   u0: RD_LAT=1, read-first,  zero fill
//   u1: RD_LAT=2, write-first, zero fill
//   u2: RD_LAT=1, write-first, no fill
module tb_rv_tdpram;
  localparam int W  = 32;
  localparam int D  = 1000;
  localparam int AW = 10;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          a_en, b_en;
  logic [BW-1:0] a_we, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [W-1:0]  a_wdata, b_wdata;
  logic [2:0]        init_done, a_rvalid, b_rvalid;
  logic [2:0][W-1:0] a_rdata, b_rdata;

  int   vectors = 0;
  int   miscompares = 0;
  logic early, seen;
  logic [W-1:0] model [D];

  rv_tdpram #(.WIDTH(W), .DEPTH(D), .RD_LAT(1), .RDW_MODE(0), .CLR_ON_RST(1)) u0 (
    .clk(clk), .rst_n(rst_n), .init_done(init_done[0]),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata[0]), .a_rvalid(a_rvalid[0]),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata[0]), .b_rvalid(b_rvalid[0]));

  rv_tdpram #(.WIDTH(W), .DEPTH(D), .RD_LAT(2), .RDW_MODE(1), .CLR_ON_RST(1)) u1 (
    .clk(clk), .rst_n(rst_n), .init_done(init_done[1]),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata[1]), .a_rvalid(a_rvalid[1]),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata[1]), .b_rvalid(b_rvalid[1]));

  rv_tdpram #(.WIDTH(W), .DEPTH(D), .RD_LAT(1), .RDW_MODE(1), .CLR_ON_RST(0)) u2 (
    .clk(clk), .rst_n(rst_n), .init_done(init_done[2]),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata[2]), .a_rvalid(a_rvalid[2]),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata[2]), .b_rvalid(b_rvalid[2]));

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_en = 1'b0; b_en = 1'b0; a_we = '0; b_we = '0;
  endtask

  task automatic port_a(input logic [BW-1:0] we, input int addr, input logic [W-1:0] d);
    a_en = 1'b1; a_we = we; a_addr = AW'(addr); a_wdata = d;
  endtask

  task automatic port_b(input logic [BW-1:0] we, input int addr, input logic [W-1:0] d);
    b_en = 1'b1; b_we = we; b_addr = AW'(addr); b_wdata = d;
  endtask

  // Back-to-back reads of every word on port B, compared with the model.
  task automatic sweep(input string tag);
    int bad0 = 0;
    int bad1 = 0;
    idle();
    for (int i = 0; i <= D; i++) begin
      if (i < D) port_b('0, i, '0);
      else       b_en = 1'b0;
      tick();
      if (i < D && (b_rvalid[0] !== 1'b1 || b_rdata[0] !== model[i])) bad0++;
      if (i > 0 && (b_rvalid[1] !== 1'b1 || b_rdata[1] !== model[i-1])) bad1++;
    end
    check({tag, "_u0_bad_words"}, W'(bad0), '0);
    check({tag, "_u1_bad_words"}, W'(bad1), '0);
  endtask

  initial begin
    for (int i = 0; i < D; i++) model[i] = '0;
    idle();
    a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_init_done", W'(init_done), '0);
    check("rst_a_rvalid", W'(a_rvalid), '0);
    check("rst_a_rdata0", a_rdata[0], '0);

    // Release, request reads during fill, then reset mid-fill.
    port_a('0, 0, '0);
    rst_n = 1'b1;
    tick();
    check("nofill_ready_u2", W'(init_done[2]), 32'd1);
    check("fill_busy_u0", W'(init_done[0]), 32'd0);
    repeat (299) tick();
    rst_n = 1'b0;
    #1;
    check("midfill_rst_init_done", W'(init_done), '0);
    check("midfill_rst_rvalid", W'({b_rvalid, a_rvalid}), '0);
    check("midfill_rst_rdata1", a_rdata[1], '0);
    tick();
    tick();
    rst_n = 1'b1;
    early = 1'b0;
    seen  = 1'b0;
    for (int i = 1; i <= D; i++) begin
      tick();
      if (i < D && (init_done[0] || init_done[1])) early = 1'b1;
      if (a_rvalid[0] || a_rvalid[1]) seen = 1'b1;
    end
    idle();
    check("fill_done_early", W'(early), '0);
    check("rvalid_during_fill", W'(seen), '0);
    check("fill_done_at_depth", W'(init_done), 32'd7);
    check("fill_rdata_held_u0", a_rdata[0], '0);
    check("fill_rdata_held_u1", a_rdata[1], '0);

    // Read the last word: latency 1 on u0, latency 2 on u1.
    port_a('0, 999, '0);
    tick();
    idle();
    check("rd999_u0_rvalid", W'(a_rvalid[0]), 32'd1);
    check("rd999_u0_rdata", a_rdata[0], '0);
    check("rd999_u1_not_yet", W'(a_rvalid[1]), 32'd0);
    tick();
    check("rd999_u1_rvalid", W'(a_rvalid[1]), 32'd1);
    check("rd999_u1_rdata", a_rdata[1], '0);
    check("rd999_u0_pulse", W'(a_rvalid[0]), 32'd0);

    sweep("fill_zero");

    // Byte enables and latency.
    port_a(4'b1111, 5, 32'hAABBCCDD);
    tick();
    check("wr5_u0_rdw_old", a_rdata[0], 32'h00000000);
    check("wr5_u0_rvalid", W'(a_rvalid[0]), 32'd0);
    port_a(4'b0101, 5, 32'h11223344);
    tick();
    check("wr5b_u0_rdw_old", a_rdata[0], 32'hAABBCCDD);
    check("wr5_u1_rdw_new", a_rdata[1], 32'hAABBCCDD);
    port_a('0, 5, '0);
    tick();
    idle();
    check("rd5_u0_rdata", a_rdata[0], 32'hAA22CC44);
    check("rd5_u0_rvalid", W'(a_rvalid[0]), 32'd1);
    check("wr5b_u1_rdw_new", a_rdata[1], 32'hAA22CC44);
    check("wr5b_u1_rvalid", W'(a_rvalid[1]), 32'd0);
    tick();
    check("rd5_u0_hold", a_rdata[0], 32'hAA22CC44);
    check("rd5_u0_pulse", W'(a_rvalid[0]), 32'd0);
    check("rd5_u1_rvalid", W'(a_rvalid[1]), 32'd1);
    model[5] = 32'hAA22CC44;

    // Same-port read-during-write on a zero word.
    port_a(4'b1111, 7, 32'hFFFFFFFF);
    tick();
    idle();
    check("rdw7_u0_old", a_rdata[0], 32'h00000000);
    check("rdw7_u0_rvalid", W'(a_rvalid[0]), 32'd0);
    check("rdw7_u2_new", a_rdata[2], 32'hFFFFFFFF);
    check("rdw7_u2_rvalid", W'(a_rvalid[2]), 32'd0);
    tick();
    check("rdw7_u1_new", a_rdata[1], 32'hFFFFFFFF);
    check("rdw7_u1_rvalid", W'(a_rvalid[1]), 32'd0);
    model[7] = 32'hFFFFFFFF;

    // Cross-port write collision on address 3.
    port_a(4'b0011, 3, 32'h11111111);
    port_b(4'b0110, 3, 32'h22222222);
    tick();
    idle();
    tick();
    port_a('0, 3, '0);
    tick();
    idle();
    check("ww3_u0", a_rdata[0], 32'h00221111);
    tick();
    check("ww3_u1", a_rdata[1], 32'h00221111);

    // B reads address 3 while A overwrites it.
    port_a(4'b1111, 3, 32'hDEADBEEF);
    port_b('0, 3, '0);
    tick();
    idle();
    check("rw3_u0_b_old", b_rdata[0], 32'h00221111);
    check("rw3_u0_b_rvalid", W'(b_rvalid[0]), 32'd1);
    tick();
    check("rw3_u1_b_old", b_rdata[1], 32'h00221111);
    check("rw3_u1_b_rvalid", W'(b_rvalid[1]), 32'd1);
    check("rw3_u1_a_new", a_rdata[1], 32'hDEADBEEF);
    model[3] = 32'hDEADBEEF;

    // Both ports read the same word.
    port_a('0, 3, '0);
    port_b('0, 3, '0);
    tick();
    idle();
    check("rr3_u0_a", a_rdata[0], 32'hDEADBEEF);
    check("rr3_u0_b", b_rdata[0], 32'hDEADBEEF);
    tick();
    check("rr3_u1_b", b_rdata[1], 32'hDEADBEEF);

    // Out-of-range read and write.
    port_a('0, 1010, '0);
    tick();
    idle();
    check("oor_rd_u0_rdata", a_rdata[0], '0);
    check("oor_rd_u0_rvalid", W'(a_rvalid[0]), 32'd1);
    tick();
    check("oor_rd_u1_rdata", a_rdata[1], '0);
    check("oor_rd_u1_rvalid", W'(a_rvalid[1]), 32'd1);
    port_a(4'b1111, 1010, 32'h5A5A5A5A);
    tick();
    idle();
    check("oor_wr_u0_rvalid", W'(a_rvalid[0]), 32'd0);
    tick();

    sweep("oor_write");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
